// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel mux with manual select and
// round-robin scan over enabled channels, valid/ready output stage.
module chan_scan_mux #(
   parameter int WIDTH = 8,
   parameter int CH    = 8,
   parameter int SELW  = $clog2(CH),
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic [CH-1:0]         en_mask,
   input  logic [CH*WIDTH-1:0]   in_bus,
   output logic [WIDTH-1:0]      dout,
   output logic [SELW-1:0]       dout_ch,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
   localparam logic [SELW-1:0] CH_LAST  = SELW'(CH - 1);

   typedef enum logic [1:0] {
      MANUAL,
      SCAN_DWELL,
      SCAN_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [SELW-1:0]   ptr_q, ptr_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic [SELW-1:0]   dout_ch_q, dout_ch_d;
   logic              dout_valid_q, dout_valid_d;

   logic              free;
   logic              cap;
   logic [SELW-1:0]   cap_ch;
   logic [WIDTH-1:0]  cap_data;
   logic [SELW-1:0]   man_ch;
   logic [SELW-1:0]   ptr_low;
   logic [SELW-1:0]   ptr_nxt;

   assign free       = !dout_valid_q || dout_ready;
   assign dout       = dout_q;
   assign dout_ch    = dout_ch_q;
   assign dout_valid = dout_valid_q;

   // Out-of-range manual selects clamp to the top channel.
   assign man_ch = (int'(sel) >= CH) ? CH_LAST : sel;

   // Lowest enabled channel, and next enabled channel after ptr (wrapping).
   always_comb begin
      ptr_low = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (en_mask[i]) ptr_low = SELW'(i);
      end
      ptr_nxt = ptr_q;
      for (int d = CH - 1; d >= 1; d--) begin
         if (en_mask[SELW'((int'(ptr_q) + d) % CH)])
            ptr_nxt = SELW'((int'(ptr_q) + d) % CH);
      end
   end

   // Mode sequencing: decides when and which channel gets captured.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      cap_ch  = ptr_q;
      unique case (state_q)
         MANUAL: begin
            cap    = free;
            cap_ch = man_ch;
            if (mode) begin
               state_d = SCAN_DWELL;
               ptr_d   = ptr_low;
               cnt_d   = '0;
            end
         end
         SCAN_DWELL: begin
            if (!mode) begin
               state_d = MANUAL;
            end else if (cnt_q == CNT_LAST) begin
               if (en_mask[ptr_q] && !free) begin
                  state_d = SCAN_WAIT;
               end else begin
                  cap   = en_mask[ptr_q];
                  ptr_d = ptr_nxt;
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SCAN_WAIT: begin
            if (!mode) begin
               state_d = MANUAL;
            end else if (free) begin
               cap     = 1'b1;
               ptr_d   = ptr_nxt;
               cnt_d   = '0;
               state_d = SCAN_DWELL;
            end
         end
         default: begin
            state_d = MANUAL;
         end
      endcase
   end

   // Output register: load on capture, drain when free, else hold.
   always_comb begin
      cap_data = '0;
      for (int i = 0; i < CH; i++) begin
         if (cap_ch == SELW'(i)) cap_data = in_bus[i*WIDTH +: WIDTH];
      end
      dout_d       = dout_q;
      dout_ch_d    = dout_ch_q;
      dout_valid_d = dout_valid_q;
      if (cap) begin
         dout_d       = cap_data;
         dout_ch_d    = cap_ch;
         dout_valid_d = 1'b1;
      end else if (free) begin
         dout_valid_d = 1'b0;
      end
   end

   // State and output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= MANUAL;
         ptr_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_ch_q    <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_ch_q    <= dout_ch_d;
         dout_valid_q <= dout_valid_d;
      end
   end

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: vector table, directed scan sequences and a
// randomized run against a behavioural model.
module tb_chan_scan_mux;

   localparam int WIDTH = 8;
   localparam int CH    = 8;
   localparam int SELW  = 3;
   localparam int DWELL = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [CH-1:0]     en_mask;
   logic [CH*WIDTH-1:0] in_bus;
   logic [WIDTH-1:0]  dout;
   logic [SELW-1:0]   dout_ch;
   logic              dout_valid;
   logic              dout_ready;

   int errors = 0;
   int checks = 0;

   chan_scan_mux #(
      .WIDTH (WIDTH),
      .CH    (CH),
      .SELW  (SELW),
      .DWELL (DWELL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .sel        (sel),
      .en_mask    (en_mask),
      .in_bus     (in_bus),
      .dout       (dout),
      .dout_ch    (dout_ch),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       mode;
      logic [2:0] sel;
      logic       rdy;
      logic [7:0] base;
      logic [7:0] e_dout;
      logic [2:0] e_ch;
      logic       e_valid;
   } vec_t;

   vec_t tbl[15];
   int   order[4] = '{0, 2, 5, 7};

   // behavioural model: scanning flag, waiting flag, dwell timer
   bit       m_scan, m_wait;
   int       m_ptr, m_timer;
   bit [7:0] m_dout;
   int       m_ch;
   bit       m_valid;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_base(input logic [7:0] b);
      for (int i = 0; i < CH; i++) in_bus[i*8 +: 8] = b + 8'(i);
   endtask

   task automatic chk(input string nm, input logic [7:0] ed,
                      input logic [2:0] ec, input logic ev);
      checks++;
      if (dout_valid !== ev || dout !== ed || dout_ch !== ec) begin
         errors++;
         $display("FAIL %s: got dout=%h ch=%0d valid=%b, want dout=%h ch=%0d valid=%b",
                  nm, dout, dout_ch, dout_valid, ed, ec, ev);
      end
   endtask

   task automatic chk_v(input string nm, input logic ev);
      checks++;
      if (dout_valid !== ev) begin
         errors++;
         $display("FAIL %s: got valid=%b, want valid=%b", nm, dout_valid, ev);
      end
   endtask

   function automatic bit bit_set(input logic [7:0] m, input int i);
      return ((m >> i) & 8'd1) != 8'd0;
   endfunction

   function automatic int low_bit(input logic [7:0] m);
      for (int i = 0; i < CH; i++) if (bit_set(m, i)) return i;
      return 0;
   endfunction

   function automatic int next_bit(input logic [7:0] m, input int p);
      for (int d = 1; d <= CH; d++)
         if (bit_set(m, (p + d) % CH)) return (p + d) % CH;
      return p;
   endfunction

   task automatic model_step();
      bit free;
      bit cap;
      int cch;
      free = !m_valid || dout_ready;
      cap  = 0;
      cch  = 0;
      if (rst) begin
         m_scan = 0; m_wait = 0; m_ptr = 0; m_timer = 0;
         m_dout = 0; m_ch = 0; m_valid = 0;
         return;
      end
      if (!m_scan) begin
         cap = free;
         cch = (int'(sel) >= CH) ? CH - 1 : int'(sel);
         if (mode) begin
            m_scan = 1; m_wait = 0;
            m_ptr = low_bit(en_mask); m_timer = 0;
         end
      end else if (!mode) begin
         m_scan = 0; m_wait = 0;
      end else if (m_wait) begin
         if (free) begin
            cap = 1; cch = m_ptr;
            m_ptr = next_bit(en_mask, m_ptr);
            m_timer = 0; m_wait = 0;
         end
      end else if (m_timer + 1 == DWELL) begin
         if (bit_set(en_mask, m_ptr) && !free) begin
            m_wait = 1;
         end else begin
            cap = bit_set(en_mask, m_ptr);
            cch = m_ptr;
            m_ptr = next_bit(en_mask, m_ptr);
            m_timer = 0;
         end
      end else begin
         m_timer++;
      end
      if (cap) begin
         m_dout  = 8'((in_bus >> (cch * 8)) & 64'hFF);
         m_ch    = cch;
         m_valid = 1;
      end else if (free) begin
         m_valid = 0;
      end
   endtask

   initial begin
      rst = 1'b1;
      mode = 1'b0;
      sel = '0;
      en_mask = 8'hA5;
      dout_ready = 1'b1;
      set_base(8'h10);

      // reset, manual sweep, manual backpressure
      tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b1, 8'h10, 8'h00, 3'd0, 1'b0};
      for (int i = 0; i < 8; i++)
         tbl[1+i] = '{1'b0, 1'b0, 3'(i), 1'b1, 8'h10, 8'h10 + 8'(i), 3'(i), 1'b1};
      tbl[9] = '{1'b0, 1'b0, 3'd3, 1'b0, 8'h10, 8'h17, 3'd7, 1'b1};
      for (int i = 0; i < 4; i++)
         tbl[10+i] = '{1'b0, 1'b0, 3'(i*3 + 1), 1'b0, 8'h20, 8'h17, 3'd7, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 3'd2, 1'b1, 8'h20, 8'h22, 3'd2, 1'b1};

      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].rst;
         mode = tbl[i].mode;
         sel = tbl[i].sel;
         dout_ready = tbl[i].rdy;
         set_base(tbl[i].base);
         tick();
         chk($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_ch, tbl[i].e_valid);
      end

      // scan with mask A5: entry edge still captures manually
      set_base(8'h10);
      en_mask = 8'hA5;
      sel = 3'd0;
      mode = 1'b1;
      tick();
      chk("scan_entry", 8'h10, 3'd0, 1'b1);
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n % 4 == 0)
            chk($sformatf("scan_n%0d", n), 8'h10 + 8'(order[(n/4 - 1) % 4]),
                3'(order[(n/4 - 1) % 4]), 1'b1);
         else
            chk_v($sformatf("scan_gap_n%0d", n), 1'b0);
      end

      // stall across a dwell end, release 3 cycles later
      dout_ready = 1'b0;
      for (int n = 21; n <= 26; n++) begin
         tick();
         chk($sformatf("stall_hold_n%0d", n), 8'h10, 3'd0, 1'b1);
      end
      dout_ready = 1'b1;
      tick();
      chk("stall_release", 8'h12, 3'd2, 1'b1);
      for (int n = 28; n <= 30; n++) begin
         tick();
         chk_v($sformatf("stall_gap_n%0d", n), 1'b0);
      end
      tick();
      chk("stall_next", 8'h15, 3'd5, 1'b1);

      // empty mask: no scan captures
      rst = 1'b1;
      tick();
      chk("rst_zero", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      en_mask = 8'h00;
      sel = 3'd4;
      tick();
      chk("mask0_entry", 8'h14, 3'd4, 1'b1);
      for (int n = 1; n <= 10; n++) begin
         tick();
         chk_v($sformatf("mask0_n%0d", n), 1'b0);
      end
      mode = 1'b0;
      tick();
      chk_v("mask0_exit", 1'b0);

      // single channel 3
      mode = 1'b1;
      en_mask = 8'h08;
      sel = 3'd1;
      tick();
      chk("single_entry", 8'h11, 3'd1, 1'b1);
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n % 4 == 0) chk($sformatf("single_n%0d", n), 8'h13, 3'd3, 1'b1);
         else chk_v($sformatf("single_gap_n%0d", n), 1'b0);
      end

      // clearing current ptr bit mid-dwell skips that channel
      mode = 1'b0;
      tick();
      chk_v("skip_exit", 1'b0);
      mode = 1'b1;
      en_mask = 8'hA5;
      sel = 3'd6;
      tick();
      chk("skip_entry", 8'h16, 3'd6, 1'b1);
      tick();
      chk_v("skip_n1", 1'b0);
      en_mask = 8'hA4;
      for (int n = 2; n <= 7; n++) begin
         tick();
         chk_v($sformatf("skip_n%0d", n), 1'b0);
      end
      tick();
      chk("skip_n8", 8'h12, 3'd2, 1'b1);

      // reset while in SCAN_WAIT holding a sample
      dout_ready = 1'b0;
      for (int n = 9; n <= 13; n++) begin
         tick();
         chk($sformatf("wait_hold_n%0d", n), 8'h12, 3'd2, 1'b1);
      end
      rst = 1'b1;
      tick();
      chk("rst_in_wait", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      dout_ready = 1'b1;
      sel = 3'd5;
      tick();
      chk("post_rst_manual", 8'h15, 3'd5, 1'b1);
      for (int n = 1; n <= 3; n++) begin
         tick();
         chk_v($sformatf("post_rst_gap_n%0d", n), 1'b0);
      end
      tick();
      chk("post_rst_scan", 8'h12, 3'd2, 1'b1);

      // randomized run against the model
      rst = 1'b1;
      mode = 1'b0;
      model_step();
      tick();
      chk("rand_rst", m_dout, 3'(m_ch), m_valid);
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel = 3'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 2))
               0: en_mask = 8'h00;
               1: en_mask = 8'(1 << $urandom_range(0, 7));
               default: en_mask = 8'($urandom);
            endcase
         end
         dout_ready = ($urandom_range(0, 3) != 0);
         in_bus = {$urandom, $urandom};
         model_step();
         tick();
         chk($sformatf("rand_c%0d", c), m_dout, 3'(m_ch), m_valid);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
